// File: rtl/avsddac_seq.sv
// avsddac_seq -- update sequencer for a bank of avsddac converters.
//
// Each channel has a shadow register, which is written through a valid/ready port,
// and a target register. An UPDATE pulse copies all shadows into the targets
// together. The outputs then move to the targets in one of two ways:
//   LOAD : all outputs jump to their targets on the next edge.
//   RAMP : each output moves at most STEP codes per cycle toward its target.
// DONE pulses for one cycle when the outputs reach the committed targets.
//
// Optional feature: define AVSDDAC_SEQ_RAMP_EN to build the RAMP state and the
// slew limiter. If the macro is not defined, the ramp input and STEP are ignored
// and every update takes the LOAD path.
//
// Ports:
//   clk        clock; every state change happens on the rising edge
//   rst_n      asynchronous reset, active low
//   wr_valid   request to write a shadow register
//   wr_ready   the block accepts a write this cycle (low in LOAD and during reset)
//   wr_ch      index of the target channel; an index >= CHANNELS is accepted and dropped
//   wr_data    code to store in the shadow register
//   update     copy all shadows into the targets (write-through with a write on the same edge)
//   ramp       sampled with update: 1 = slew-limited ramp, 0 = immediate load
//   d_out      packed channel codes; channel 0 is in bits WIDTH-1:0
//   busy       high whenever the state is not IDLE
//   done       one-cycle pulse when the outputs reach their targets
//   dbg_state  current FSM state (0 = IDLE, 1 = LOAD, 2 = RAMP)
//
// Handshake: a write takes place on a rising edge where wr_valid and wr_ready
// are both 1. wr_ready does not depend on wr_valid. wr_valid may be raised or
// dropped at any time, and a write is never held back for a later edge.
module avsddac_seq #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 2,
  parameter int STEP     = 4,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      update,
  input  logic                      ramp,
  output logic [CHANNELS*WIDTH-1:0] d_out,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                dbg_state
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

`ifdef AVSDDAC_SEQ_RAMP_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_RAMP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q [CHANNELS];
  logic [WIDTH-1:0] shadow_d [CHANNELS];
  logic [WIDTH-1:0] target_q [CHANNELS];
  logic [WIDTH-1:0] target_d [CHANNELS];
  logic [WIDTH-1:0] dout_q   [CHANNELS];
  logic [WIDTH-1:0] dout_d   [CHANNELS];
  logic             wr_ready_q, wr_ready_d;
  logic             done_q, done_d;
  logic             wr_fire;
  logic             upd_fire;

  assign wr_fire  = wr_valid & wr_ready_q;
  // An update during LOAD is ignored. In IDLE and RAMP it captures the targets.
  assign upd_fire = update & (state_q != S_LOAD);

`ifdef AVSDDAC_SEQ_RAMP_EN
  logic [WIDTH-1:0] step_val [CHANNELS];
  logic             all_reached;

  // Slew limiter: each channel moves by min(STEP, |target - current|), so it
  // cannot overshoot. The two branches keep the subtraction non-negative.
  always_comb begin
    all_reached = 1'b1;
    for (int c = 0; c < CHANNELS; c++) begin
      if (target_q[c] > dout_q[c]) begin
        step_val[c] = ((target_q[c] - dout_q[c]) > STEP_W) ? (dout_q[c] + STEP_W) : target_q[c];
      end else begin
        step_val[c] = ((dout_q[c] - target_q[c]) > STEP_W) ? (dout_q[c] - STEP_W) : target_q[c];
      end
      if (step_val[c] != target_q[c]) all_reached = 1'b0;
    end
  end
`else
  // Without the ramp feature these inputs have no effect.
  logic unused_cfg;
  assign unused_cfg = ^{ramp, STEP_W};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef AVSDDAC_SEQ_RAMP_EN
      S_IDLE: if (update) state_d = ramp ? S_RAMP : S_LOAD;
      // A retarget keeps the ramp running, even if the old targets were just reached.
      S_RAMP: if (!update && all_reached) state_d = S_IDLE;
`else
      S_IDLE: if (update) state_d = S_LOAD;
`endif
      S_LOAD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      // An out-of-range wr_ch matches no channel, so the write is dropped.
      shadow_d[c] = shadow_q[c];
      if (wr_fire && (int'(wr_ch) == c)) shadow_d[c] = wr_data;
      // shadow_d already holds a write on this edge, which gives write-through.
      target_d[c] = upd_fire ? shadow_d[c] : target_q[c];
      dout_d[c]   = dout_q[c];
      if (state_q == S_LOAD) dout_d[c] = target_q[c];
`ifdef AVSDDAC_SEQ_RAMP_EN
      if (state_q == S_RAMP) dout_d[c] = step_val[c];
`endif
    end
    done_d = (state_q == S_LOAD);
`ifdef AVSDDAC_SEQ_RAMP_EN
    if ((state_q == S_RAMP) && !update && all_reached) done_d = 1'b1;
`endif
    wr_ready_d = (state_d != S_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        shadow_q[c] <= '0;
        target_q[c] <= '0;
        dout_q[c]   <= '0;
      end
      wr_ready_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        shadow_q[c] <= shadow_d[c];
        target_q[c] <= target_d[c];
        dout_q[c]   <= dout_d[c];
      end
      wr_ready_q <= wr_ready_d;
      done_q     <= done_d;
    end
  end

  // Outputs
  always_comb begin
    d_out = '0;
    for (int c = 0; c < CHANNELS; c++) d_out[c*WIDTH +: WIDTH] = dout_q[c];
    busy      = (state_q != S_IDLE);
    done      = done_q;
    wr_ready  = wr_ready_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_avsddac_seq.sv
module tb_avsddac_seq;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // Main DUT: WIDTH=10, CHANNELS=2, STEP=4
  logic        wr_valid, wr_ready, wr_ch, update, ramp, busy, done;
  logic [9:0]  wr_data;
  logic [19:0] d_out;
  logic [1:0]  dbg_state;

  avsddac_seq #(.WIDTH(10), .CHANNELS(2), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_ch(wr_ch), .wr_data(wr_data), .update(update), .ramp(ramp),
    .d_out(d_out), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Second DUT with 3 channels, so that wr_ch=3 is out of range
  logic        b_wr_valid, b_wr_ready, b_update, b_busy, b_done;
  logic [1:0]  b_wr_ch, b_dbg_state;
  logic [9:0]  b_wr_data;
  logic [29:0] b_d_out;

  avsddac_seq #(.WIDTH(10), .CHANNELS(3), .STEP(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
    .wr_ch(b_wr_ch), .wr_data(b_wr_data), .update(b_update), .ramp(1'b0),
    .d_out(b_d_out), .busy(b_busy), .done(b_done), .dbg_state(b_dbg_state)
  );

  // Scoreboard counters
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic ch, input logic [9:0] data);
    wr_valid = 1'b1; wr_ch = ch; wr_data = data;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic upd(input logic r);
    update = 1'b1; ramp = r;
    tick();
    update = 1'b0; ramp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset_dout", {12'd0, d_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 0; wr_ch = 0; wr_data = 0; update = 0; ramp = 0;
    b_wr_valid = 0; b_wr_ch = 0; b_wr_data = 0; b_update = 0;
    #2;
    chk("rst_dout",  {12'd0, d_out}, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_ready", wr_ready, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel_ready", wr_ready, 1);
    chk("rel_dout",  {12'd0, d_out}, 0);
    chk("rel_busy",  busy, 0);
    chk("rel_done",  done, 0);

    // Immediate load
    wr(1'b0, 10'd1023);
    wr(1'b1, 10'd512);
    upd(1'b0);
    chk("load_busy",  busy, 1);
    chk("load_ready", wr_ready, 0);
    chk("load_dout",  {12'd0, d_out}, 0);
    chk("load_done0", done, 0);
    tick();
    chk("load_ch0",   d_out[9:0], 1023);
    chk("load_ch1",   d_out[19:10], 512);
    chk("load_idle",  busy, 0);
    chk("load_done",  done, 1);
    chk("load_rdy1",  wr_ready, 1);
    tick();
    chk("load_done_end", done, 0);

    // Write-through: the write and the update happen on the same edge
    wr_valid = 1'b1; wr_ch = 1'b1; wr_data = 10'd700; update = 1'b1;
    tick();
    wr_valid = 1'b0; update = 1'b0;
    chk("wt_busy", busy, 1);
    tick();
    chk("wt_ch1",  d_out[19:10], 700);
    chk("wt_ch0",  d_out[9:0], 1023);
    chk("wt_done", done, 1);

    // Targets already equal to the outputs: one DONE pulse after one cycle
    upd(1'b0);
    chk("same_busy",  busy, 1);
    chk("same_done0", done, 0);
    tick();
    chk("same_done",  done, 1);
    chk("same_ch1",   d_out[19:10], 700);
    tick();

`ifdef AVSDDAC_SEQ_RAMP_EN
    do_reset();
    wr(1'b0, 10'd10);
    wr(1'b1, 10'd3);
    upd(1'b1);
    chk("rmp_busy",  busy, 1);
    chk("rmp_ready", wr_ready, 1);
    chk("rmp_dout0", {12'd0, d_out}, 0);
    tick();
    chk("rmp_s1_ch0", d_out[9:0], 4);
    chk("rmp_s1_ch1", d_out[19:10], 3);
    chk("rmp_s1_done", done, 0);
    tick();
    chk("rmp_s2_ch0", d_out[9:0], 8);
    chk("rmp_s2_ch1", d_out[19:10], 3);
    tick();
    chk("rmp_s3_ch0", d_out[9:0], 10);
    chk("rmp_s3_done", done, 1);
    chk("rmp_s3_busy", busy, 0);
    tick();
    chk("rmp_done_end", done, 0);

    // Ramp down
    wr(1'b0, 10'd0);
    upd(1'b1);
    tick();
    chk("dn_s1", d_out[9:0], 6);
    tick();
    chk("dn_s2", d_out[9:0], 2);
    chk("dn_s2_done", done, 0);
    tick();
    chk("dn_s3", d_out[9:0], 0);
    chk("dn_ch1", d_out[19:10], 3);
    chk("dn_done", done, 1);
    tick();

    // Retarget during a ramp
    wr(1'b0, 10'd20);
    upd(1'b1);
    tick();
    chk("rt_s1", d_out[9:0], 4);
    wr_valid = 1'b1; wr_ch = 1'b0; wr_data = 10'd5; update = 1'b1; ramp = 1'b1;
    tick();
    wr_valid = 1'b0; update = 1'b0; ramp = 1'b0;
    chk("rt_s2",      d_out[9:0], 8);
    chk("rt_s2_done", done, 0);
    chk("rt_s2_busy", busy, 1);
    tick();
    chk("rt_s3",      d_out[9:0], 5);
    chk("rt_s3_done", done, 1);
    tick();

    // Ramp to targets that are already reached
    upd(1'b1);
    chk("rsame_busy", busy, 1);
    tick();
    chk("rsame_done", done, 1);
    chk("rsame_ch0",  d_out[9:0], 5);
    tick();

    // Reset in the middle of a ramp
    do_reset();
    wr(1'b0, 10'd10);
    upd(1'b1);
    tick();
    tick();
    chk("mid_ch0", d_out[9:0], 8);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_dout",  {12'd0, d_out}, 0);
    chk("mid_rst_done",  done, 0);
    chk("mid_rst_busy",  busy, 0);
    chk("mid_rst_ready", wr_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_post_done", done, 0);
    chk("mid_post_busy", busy, 0);
    tick();
    chk("mid_post_done2", done, 0);
`else
    // Without the ramp feature, ramp=1 still takes the LOAD path
    wr(1'b0, 10'd10);
    upd(1'b1);
    chk("nr_busy",  busy, 1);
    chk("nr_ready", wr_ready, 0);
    tick();
    chk("nr_ch0",  d_out[9:0], 10);
    chk("nr_done", done, 1);
    chk("nr_idle", busy, 0);
    tick();

    // Reset in the middle of a LOAD
    wr(1'b0, 10'd20);
    upd(1'b0);
    chk("ml_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ml_rst_dout", {12'd0, d_out}, 0);
    chk("ml_rst_done", done, 0);
    chk("ml_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("ml_post_done", done, 0);
    chk("ml_post_dout", {12'd0, d_out}, 0);
`endif

    // Out-of-range channel index on the 3-channel instance
    for (int i = 0; i < 3; i++) begin
      b_wr_valid = 1'b1; b_wr_ch = 2'(i); b_wr_data = 10'(100 * (i + 1));
      tick();
    end
    b_wr_valid = 1'b0;
    b_update = 1'b1;
    tick();
    b_update = 1'b0;
    tick();
    chk("b_load", {2'd0, b_d_out}, (32'd300 << 20) | (32'd200 << 10) | 32'd100);
    chk("b_done", b_done, 1);
    b_wr_valid = 1'b1; b_wr_ch = 2'd3; b_wr_data = 10'd999;
    tick();
    b_wr_valid = 1'b0;
    b_update = 1'b1;
    tick();
    b_update = 1'b0;
    tick();
    chk("b_drop", {2'd0, b_d_out}, (32'd300 << 20) | (32'd200 << 10) | 32'd100);
    chk("b_drop_done", b_done, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
